maxpool2d_stream: RTL
=====================

MAXPOOL2D_STREAM -- requirements
Module: maxpool2d_stream

Interface
REQ-001 SHALL have parameter F_IN_W, default 26, input feature-map width in pixels.
REQ-002 SHALL have parameter F_IN_H, default 11, input feature-map height in pixels.
REQ-003 SHALL have parameter F_IN_D, default 4, channel count processed in parallel.
REQ-004 SHALL derive F_OUT_W = F_IN_W/2 and F_OUT_H = F_IN_H/2 (floor) as localparams; data width FEATURE_MAP_RESOLUTION and address width FEATURE_MAP_ADDRWIDE come from pkg_parameters.
REQ-005 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port feature_in_valid_i, input, 1, input pixel valid for all channels.
REQ-008 SHALL have port feature_in_data_i, input, FEATURE_MAP_RESOLUTION x F_IN_D, signed pixel per channel.
REQ-009 SHALL have port feature_in_addr_i, input, FEATURE_MAP_ADDRWIDE, raster index row*F_IN_W+col.
REQ-010 SHALL have port feature_in_ready_o, output, 1, block accepts a pixel this cycle.
REQ-011 SHALL have port feature_out_valid_o, output, 1, pooled pixel valid.
REQ-012 SHALL have port feature_out_data_o, output, FEATURE_MAP_RESOLUTION x F_IN_D, signed pooled value per channel.
REQ-013 SHALL have port feature_out_addr_o, output, FEATURE_MAP_ADDRWIDE, pooled raster index (row/2)*F_OUT_W+col/2.
REQ-014 SHALL have port feature_out_ready_i, input, 1, downstream accepts.
REQ-015 SHALL have port addr_err_o, output, 1, sticky address-mismatch flag.

Function
REQ-016 SHALL perform 2x2, stride-2, signed max pooling per channel on a raster-ordered input stream.
REQ-017 SHALL transfer an input pixel only when feature_in_valid_i and feature_in_ready_o are both high.
REQ-018 SHALL drive feature_in_ready_o = !feature_out_valid_o || feature_out_ready_i (one-entry output register, no combinational path from valid to ready).
REQ-019 SHALL track position with internal col (0..F_IN_W-1) and row (0..F_IN_H-1) counters advanced per transfer; col wraps to 0 and row increments at F_IN_W-1; both wrap to 0 after the last frame pixel.
REQ-020 SHALL run FSM ROW_EVEN -> ROW_ODD -> ROW_EVEN per row pair; after row F_IN_H-2 with F_IN_H odd, SHALL enter ROW_DROP for the final row, then return to ROW_EVEN at frame wrap.
REQ-021 ROW_EVEN: even col loads hold register; odd col writes max(hold, pixel) into line buffer entry col/2 (F_OUT_W entries per channel).
REQ-022 ROW_ODD: even col loads hold; odd col computes max(hold, pixel, linebuf[col/2]) into the output register, sets feature_out_valid_o and feature_out_addr_o next cycle (latency 1 cycle from the completing transfer).
REQ-023 If F_IN_W is odd, pixel at col F_IN_W-1 SHALL be accepted and discarded; ROW_DROP pixels SHALL be accepted and discarded.
REQ-024 feature_out_valid_o SHALL hold with stable data/addr until feature_out_ready_i; simultaneous output handshake and new completing input SHALL reload the register with no bubble.
REQ-025 Comparisons SHALL be signed two's complement; equal values yield that value; no saturation or width growth.

Reset
REQ-026 On rst_i high, asynchronously: feature_out_valid_o=0, feature_out_data_o=0, feature_out_addr_o=0, addr_err_o=0, counters=0, FSM=ROW_EVEN; line buffer and hold need not clear.
REQ-027 Reset mid-frame SHALL discard the partial frame; first transfer after release is pixel (0,0).

Configuration
REQ-028 With macro MAXPOOL_ADDR_CHECK_EN defined, each transfer SHALL compare feature_in_addr_i to row*F_IN_W+col and set addr_err_o on mismatch, sticky until reset; pooling unaffected.
REQ-029 Without MAXPOOL_ADDR_CHECK_EN, feature_in_addr_i SHALL be ignored and addr_err_o tied to 0.

Verification
REQ-030 F_IN_W=4,F_IN_H=4,D=1, input 0..15 raster, ready_i=1 -> outputs 5,7,13,15 at addr 0,1,2,3, each 1 cycle after pixels 5,7,13,15.
REQ-031 Signed: 2x2 frame {-128,-3,-7,-100} -> single output -3, addr 0.
REQ-032 F_IN_W=5,F_IN_H=5, input 0..24 -> outputs 6,8,16,18; col 4 and row 4 consumed, no extra outputs; next frame restarts at addr 0.
REQ-033 ready_i=0 while output valid -> feature_in_ready_o=0, output data/addr stable; ready_i=1 with next completing pixel -> back-to-back outputs.
REQ-034 rst_i pulsed after 6 pixels of a 4x4 frame -> all outputs 0; fresh frame 0..15 yields 5,7,13,15.
REQ-035 With MAXPOOL_ADDR_CHECK_EN, pixel 3 sent with addr 9 -> addr_err_o=1 next cycle and stays 1 until rst_i; without macro stays 0.

Source files
------------

// File: rtl/maxpool2d_stream.sv
// 2x2 stride-2 signed max pooling over a raster-ordered multi-channel pixel stream.
// Optional input address checking is enabled with `define MAXPOOL_ADDR_CHECK_EN.
package pkg_parameters;
    localparam int FEATURE_MAP_RESOLUTION = 8;
    localparam int FEATURE_MAP_ADDRWIDE   = 16;
endpackage

module maxpool2d_stream
    import pkg_parameters::*;
#(
    parameter int F_IN_W = 26,
    parameter int F_IN_H = 11,
    parameter int F_IN_D = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     feature_in_valid_i,
    input  logic [FEATURE_MAP_RESOLUTION*F_IN_D-1:0] feature_in_data_i,
    input  logic [FEATURE_MAP_ADDRWIDE-1:0]          feature_in_addr_i,
    output logic                                     feature_in_ready_o,
    output logic                                     feature_out_valid_o,
    output logic [FEATURE_MAP_RESOLUTION*F_IN_D-1:0] feature_out_data_o,
    output logic [FEATURE_MAP_ADDRWIDE-1:0]          feature_out_addr_o,
    input  logic                                     feature_out_ready_i,
    output logic                                     addr_err_o
);
    localparam int F_OUT_W = F_IN_W / 2;
    localparam int F_OUT_H = F_IN_H / 2;
    localparam int RES     = FEATURE_MAP_RESOLUTION;
    localparam int AW      = FEATURE_MAP_ADDRWIDE;
    localparam int COL_W   = (F_IN_W > 1) ? $clog2(F_IN_W) : 1;
    localparam int ROW_W   = (F_IN_H > 1) ? $clog2(F_IN_H) : 1;
    localparam int LB_W    = (F_OUT_W > 1) ? $clog2(F_OUT_W) : 1;

    typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, ROW_DROP} state_t;
    typedef logic signed [RES-1:0] pix_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    pix_t               hold     [F_IN_D];
    pix_t               linebuf  [F_OUT_W][F_IN_D];
    pix_t               pair_max [F_IN_D];
    pix_t               pool_max [F_IN_D];
    logic [RES*F_IN_D-1:0] pool_flat;
    logic               in_fire;
    logic               last_col;
    logic               last_row;
    logic               drop_next;
    logic               lb_wr;
    logic               complete;
    logic [LB_W-1:0]    lb_idx;
    logic [AW-1:0]      out_addr_next;

    assign feature_in_ready_o = !feature_out_valid_o || feature_out_ready_i;
    assign in_fire   = feature_in_valid_i && feature_in_ready_o;
    assign last_col  = (col == COL_W'(F_IN_W - 1));
    assign last_row  = (row == ROW_W'(F_IN_H - 1));
    // An odd-height frame leaves one unpaired row after the last full row pair.
    assign drop_next = (F_IN_H % 2 == 1) && (row == ROW_W'(2 * F_OUT_H - 1));
    assign lb_idx    = LB_W'(col >> 1);
    assign lb_wr     = in_fire && (state == ROW_EVEN) && col[0];
    assign complete  = in_fire && (state == ROW_ODD) && col[0];
    assign out_addr_next = AW'(row >> 1) * AW'(F_OUT_W) + AW'(col >> 1);

    always_comb begin
        pool_flat = '0;
        for (int unsigned c = 0; c < F_IN_D; c++) begin
            pix_t p;
            p           = feature_in_data_i[c*RES +: RES];
            pair_max[c] = (hold[c] > p) ? hold[c] : p;
            pool_max[c] = (pair_max[c] > linebuf[lb_idx][c]) ? pair_max[c] : linebuf[lb_idx][c];
            pool_flat[c*RES +: RES] = pool_max[c];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned c = 0; c < F_IN_D; c++) begin
            if (in_fire && !col[0])
                hold[c] <= feature_in_data_i[c*RES +: RES];
            if (lb_wr)
                linebuf[lb_idx][c] <= pair_max[c];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= ROW_EVEN;
            col                 <= '0;
            row                 <= '0;
            feature_out_valid_o <= 1'b0;
            feature_out_data_o  <= '0;
            feature_out_addr_o  <= '0;
        end else begin
            if (in_fire) begin
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row   <= '0;
                        state <= ROW_EVEN;
                    end else begin
                        row <= row + 1'b1;
                        unique case (state)
                            ROW_EVEN: state <= ROW_ODD;
                            ROW_ODD:  state <= drop_next ? ROW_DROP : ROW_EVEN;
                            default:  state <= ROW_EVEN;
                        endcase
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (complete) begin
                feature_out_valid_o <= 1'b1;
                feature_out_data_o  <= pool_flat;
                feature_out_addr_o  <= out_addr_next;
            end else if (feature_out_ready_i) begin
                feature_out_valid_o <= 1'b0;
            end
        end
    end

`ifdef MAXPOOL_ADDR_CHECK_EN
    logic [AW-1:0] exp_in_addr;
    assign exp_in_addr = AW'(row) * AW'(F_IN_W) + AW'(col);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            addr_err_o <= 1'b0;
        else if (in_fire && (feature_in_addr_i != exp_in_addr))
            addr_err_o <= 1'b1;
    end
`else
    assign addr_err_o = 1'b0;
`endif

endmodule
